// File: rtl/fp32_mult_seq.sv
`default_nettype none
// ============================================================================
//  Module   : fp32_mult_seq
//  Purpose  : Iterative shift-add FP32 multiplier with valid/ready handshakes.
//             Specials are resolved when operands are accepted. Finite operands
//             take 24 radix-2 steps, then a normalise/round/range-check cycle.
//             Subnormal inputs are flushed to zero.
//  Options  : FPMUL_RNE_EN - round-to-nearest-even (guard + sticky).
//             When it is undefined the low product bits are truncated.
//  Revision : 1.0 - initial release
// ============================================================================
module fp32_mult_seq #(
    parameter int BIT_WIDTH  = 32,
    parameter int EXP_WIDTH  = 8,
    parameter int MANT_WIDTH = 23,
    parameter int BIAS       = 127
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BIT_WIDTH-1:0] a_operand,
    input  logic [BIT_WIDTH-1:0] b_operand,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [BIT_WIDTH-1:0] result,
    output logic                 overflow,
    output logic                 underflow,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int C_SIG_W  = MANT_WIDTH + 1;
    localparam int C_PROD_W = 2 * C_SIG_W;
    localparam int C_ESUM_W = EXP_WIDTH + 2;
    localparam int C_CNT_W  = 5;
    localparam logic [EXP_WIDTH-1:0]       C_EXP_ONES = '1;
    localparam logic signed [C_ESUM_W:0]   C_BIAS     = (C_ESUM_W+1)'(BIAS);
    localparam logic signed [C_ESUM_W:0]   C_EXP_MAX  = (C_ESUM_W+1)'((1 << EXP_WIDTH) - 1);
    localparam logic [C_CNT_W-1:0]         C_LAST     = C_CNT_W'(C_SIG_W - 1);
    localparam logic [BIT_WIDTH-1:0]       C_QNAN     = {1'b0, C_EXP_ONES, 1'b1, (MANT_WIDTH-1)'(0)};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_NORM = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic                   sign_q, sign_d;
    logic [C_ESUM_W-1:0]    esum_q, esum_d;
    logic [C_PROD_W-1:0]    mcand_q, mcand_d;
    logic [C_SIG_W-1:0]     mplier_q, mplier_d;
    logic [C_PROD_W-1:0]    acc_q, acc_d;
    logic [C_CNT_W-1:0]     count_q, count_d;
    logic [BIT_WIDTH-1:0]   result_q, result_d;
    logic                   ovf_q, ovf_d;
    logic                   udf_q, udf_d;

    // ---------------- operand decode ----------------
    logic [EXP_WIDTH-1:0]   w_ea, w_eb;
    logic [MANT_WIDTH-1:0]  w_ma, w_mb;
    logic                   w_sign_in;
    logic                   w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic                   w_special, w_nan_case;
    logic [BIT_WIDTH-1:0]   w_spec_res;

    assign w_ea       = a_operand[BIT_WIDTH-2 -: EXP_WIDTH];
    assign w_eb       = b_operand[BIT_WIDTH-2 -: EXP_WIDTH];
    assign w_ma       = a_operand[MANT_WIDTH-1:0];
    assign w_mb       = b_operand[MANT_WIDTH-1:0];
    assign w_sign_in  = a_operand[BIT_WIDTH-1] ^ b_operand[BIT_WIDTH-1];
    // Exponent zero covers both true zero and flushed subnormals.
    assign w_a_zero   = (w_ea == '0);
    assign w_b_zero   = (w_eb == '0);
    assign w_a_inf    = (w_ea == C_EXP_ONES) && (w_ma == '0);
    assign w_b_inf    = (w_eb == C_EXP_ONES) && (w_mb == '0);
    assign w_a_nan    = (w_ea == C_EXP_ONES) && (w_ma != '0);
    assign w_b_nan    = (w_eb == C_EXP_ONES) && (w_mb != '0);
    assign w_special  = w_a_zero | w_b_zero | (w_ea == C_EXP_ONES) | (w_eb == C_EXP_ONES);
    assign w_nan_case = w_a_nan | w_b_nan | (w_a_inf & w_b_zero) | (w_a_zero & w_b_inf);
    assign w_spec_res = w_nan_case          ? C_QNAN :
                        (w_a_inf | w_b_inf) ? {w_sign_in, C_EXP_ONES, MANT_WIDTH'(0)} :
                                              {w_sign_in, (BIT_WIDTH-1)'(0)};

    // ---------------- normalise / round / range ----------------
    // A product of two [1,2) significands has its leading one at bit 47 or bit 46.
    logic                    w_shift, w_inc, w_carry, w_ovf, w_udf;
    logic [C_SIG_W-1:0]      w_sig;
    logic [C_SIG_W:0]        w_sig_rnd;
    logic [MANT_WIDTH-1:0]   w_mant;
    logic signed [C_ESUM_W:0] w_exp;
    logic [BIT_WIDTH-1:0]    w_norm_res;

    assign w_shift = acc_q[C_PROD_W-1];
    assign w_sig   = w_shift ? acc_q[C_PROD_W-1 -: C_SIG_W] : acc_q[C_PROD_W-2 -: C_SIG_W];

`ifdef FPMUL_RNE_EN
    logic w_guard, w_sticky;
    assign w_guard  = w_shift ? acc_q[C_SIG_W-1] : acc_q[C_SIG_W-2];
    assign w_sticky = w_shift ? (|acc_q[C_SIG_W-2:0]) : (|acc_q[C_SIG_W-3:0]);
    assign w_inc    = w_guard & (w_sticky | w_sig[0]);
`else
    assign w_inc    = 1'b0;
`endif

    assign w_sig_rnd  = {1'b0, w_sig} + {{C_SIG_W{1'b0}}, w_inc};
    // A rounding carry-out of the significand means the value reached 2.0.
    assign w_carry    = w_sig_rnd[C_SIG_W];
    assign w_mant     = w_carry ? w_sig_rnd[C_SIG_W-1:1] : w_sig_rnd[MANT_WIDTH-1:0];
    assign w_exp      = $signed({1'b0, esum_q})
                      + $signed({{C_ESUM_W{1'b0}}, w_shift})
                      + $signed({{C_ESUM_W{1'b0}}, w_carry})
                      - C_BIAS;
    assign w_ovf      = (w_exp >= C_EXP_MAX);
    assign w_udf      = w_exp[C_ESUM_W] | (w_exp == '0);
    assign w_norm_res = w_ovf ? {sign_q, C_EXP_ONES, MANT_WIDTH'(0)} :
                        w_udf ? {sign_q, (BIT_WIDTH-1)'(0)} :
                                {sign_q, w_exp[EXP_WIDTH-1:0], w_mant};

    // State register and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            sign_q   <= 1'b0;
            esum_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            esum_q   <= esum_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Next-state and datapath update for accept, shift-add steps, normalise and hand-off.
    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        esum_d   = esum_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sign_d = w_sign_in;
                    if (w_special) begin
                        result_d = w_spec_res;
                        ovf_d    = 1'b0;
                        udf_d    = 1'b0;
                        state_d  = S_DONE;
                    end else begin
                        esum_d   = {2'b00, w_ea} + {2'b00, w_eb};
                        mcand_d  = {{C_SIG_W{1'b0}}, 1'b1, w_ma};
                        mplier_d = {1'b1, w_mb};
                        acc_d    = '0;
                        count_d  = '0;
                        state_d  = S_MUL;
                    end
                end
            end
            S_MUL: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + 1'b1;
                if (count_q == C_LAST) begin
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                result_d = w_norm_res;
                ovf_d    = w_ovf;
                udf_d    = w_udf;
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign overflow  = ovf_q;
    assign underflow = udf_q;

endmodule
`default_nettype wire

// File: tb/tb_fp32_mult_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp32_mult_seq
//  Purpose  : Self-checking bench for fp32_mult_seq: directed vector table,
//             back-pressure and reset-abort sequences, and random operands
//             checked against an arithmetic reference model.
//             Define FPMUL_RNE_EN identically for the bench and the design.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fp32_mult_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a_operand, b_operand;
    logic        in_valid, in_ready;
    logic [31:0] result;
    logic        overflow, underflow, out_valid, out_ready;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ov;
        logic        uf;
        int          lat;
    } vec_t;

    fp32_mult_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_operand (a_operand),
        .b_operand (b_operand),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %08h required %08h", name, act, req);
        end
    endtask

    // Reference: exact integer significand product, then normalise, round, range-check.
    function automatic vec_t model(input logic [31:0] a, input logic [31:0] b);
        vec_t v;
        logic s;
        int ea, eb, e;
        logic [22:0] ma, mb;
        bit an, bn, ai, bi, az, bz, lost;
        longint unsigned p, sig, rem, pa, pb;
        v.a = a; v.b = b; v.ov = 1'b0; v.uf = 1'b0; v.lat = 1;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]); eb = int'(b[30:23]);
        ma = a[22:0];        mb = b[22:0];
        an = (ea == 255) && (ma != 0); bn = (eb == 255) && (mb != 0);
        ai = (ea == 255) && (ma == 0); bi = (eb == 255) && (mb == 0);
        az = (ea == 0);                bz = (eb == 0);
        if (an || bn || (ai && bz) || (az && bi)) begin
            v.res = 32'h7FC00000;
        end else if (ai || bi) begin
            v.res = {s, 31'h7F800000};
        end else if (az || bz) begin
            v.res = {s, 31'h0};
        end else begin
            v.lat = 26;
            pa = {40'd0, 1'b1, ma};
            pb = {40'd0, 1'b1, mb};
            p  = pa * pb;
            e  = ea + eb - 127;
            lost = 1'b0;
            if (p >= (64'd1 << 47)) begin
                lost = p[0];
                p = p >> 1;
                e = e + 1;
            end
            sig = p >> 23;
            rem = p & 64'h7FFFFF;
`ifdef FPMUL_RNE_EN
            if (rem[22] && (((rem & 64'h3FFFFF) != 0) || lost || sig[0])) sig = sig + 1;
`else
            if (lost && rem == 64'hFFFF_FFFF) sig = sig + 1;
`endif
            if (sig == (64'd1 << 24)) begin
                sig = sig >> 1;
                e = e + 1;
            end
            if (e >= 255) begin
                v.res = {s, 8'hFF, 23'h0};
                v.ov  = 1'b1;
            end else if (e <= 0) begin
                v.res = {s, 31'h0};
                v.uf  = 1'b1;
            end else begin
                v.res = {s, 8'(e), sig[22:0]};
            end
        end
        return v;
    endfunction

    // One transaction: accept, measure latency, check outputs, optional back-pressure, release.
    task automatic run_op(input vec_t v, input int hold, input string name);
        int lat;
        @(negedge clk);
        a_operand = v.a;
        b_operand = v.b;
        in_valid  = 1'b1;
        check({name, " in_ready_idle"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        a_operand = $urandom;
        b_operand = $urandom;
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, " latency"}, 32'(lat), 32'(v.lat));
        check({name, " result"}, result, v.res);
        check({name, " flags"}, {30'd0, overflow, underflow}, {30'd0, v.ov, v.uf});
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            check({name, " hold out_valid"}, 32'(out_valid), 32'd1);
            check({name, " hold in_ready"}, 32'(in_ready), 32'd0);
            check({name, " hold result"}, result, v.res);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, " in_ready_after"}, 32'(in_ready), 32'd1);
        check({name, " out_valid_after"}, 32'(out_valid), 32'd0);
    endtask

    function automatic logic [31:0] rand_fp();
        int sel, e;
        sel = $urandom_range(0, 19);
        if (sel == 0)      e = 0;
        else if (sel == 1) e = 255;
        else if (sel < 5)  e = $urandom_range(190, 254);
        else if (sel < 8)  e = $urandom_range(1, 64);
        else               e = $urandom_range(100, 154);
        return {1'($urandom), 8'(e), 23'($urandom)};
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[13];
        vec_t v;
        tbl[0]  = '{32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 1'b0, 26};
        tbl[1]  = '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b0, 1'b0, 26};
`ifdef FPMUL_RNE_EN
        tbl[2]  = '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 1'b0, 1'b0, 26};
`else
        tbl[2]  = '{32'h3F800001, 32'h3FC00000, 32'h3FC00001, 1'b0, 1'b0, 26};
`endif
        tbl[3]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1, 1'b0, 26};
        tbl[4]  = '{32'h00800000, 32'h00800000, 32'h00000000, 1'b0, 1'b1, 26};
        tbl[5]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b0, 1};
        tbl[6]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 1'b0, 1'b0, 1};
        tbl[7]  = '{32'hC0000000, 32'h40400000, 32'hC0C00000, 1'b0, 1'b0, 26};
        tbl[8]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b0, 1};
        tbl[9]  = '{32'h80000000, 32'h40400000, 32'h80000000, 1'b0, 1'b0, 1};
        tbl[10] = '{32'h00000001, 32'h40000000, 32'h00000000, 1'b0, 1'b0, 1};
        tbl[11] = '{32'hFF800000, 32'hFF800000, 32'h7F800000, 1'b0, 1'b0, 1};
        tbl[12] = '{32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 1'b0, 1'b0, 26};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_operand = '0;
        b_operand = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset result", result, 32'd0);
        check("reset flags", {30'd0, overflow, underflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_op(tbl[i], 0, $sformatf("vec%0d", i));
        end

        // Back-pressure: consumer stalls for ten cycles.
        run_op(tbl[0], 10, "hold");

        // Reset asserted part-way through the shift-add steps.
        @(negedge clk);
        a_operand = 32'h40000000;
        b_operand = 32'h40400000;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort in_ready", 32'(in_ready), 32'd1);
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("abort no result", 32'(out_valid), 32'd0);
        run_op(tbl[1], 0, "after_abort");

        for (int i = 0; i < 150; i++) begin
            v = model(rand_fp(), rand_fp());
            run_op(v, i % 7 == 0 ? 2 : 0, $sformatf("rand%0d %08h*%08h", i, v.a, v.b));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
